// File: rtl/count_sort_core_pkg.sv
// Shared types and default widths for the counting-sort engine.
package sort_pkg;

    localparam int unsigned SORT_VALUE_WIDTH = 10;
    localparam int unsigned SORT_COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } sort_state_e;

endpackage

// File: rtl/count_sort_core_if.sv
// Input and output valid/ready streams of the counting-sort engine.
interface count_sort_core_if
    import sort_pkg::*;
#(
    parameter int unsigned VALUE_WIDTH = SORT_VALUE_WIDTH
) ();

    logic [VALUE_WIDTH-1:0] in_data;
    logic                   in_last;
    logic                   in_valid;
    logic                   in_ready;
    logic [VALUE_WIDTH-1:0] out_data;
    logic                   out_last;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output in_data, in_last, in_valid, out_ready,
        input  in_ready, out_data, out_last, out_valid
    );

    modport slave (
        input  in_data, in_last, in_valid, out_ready,
        output in_ready, out_data, out_last, out_valid
    );

endinterface

// File: rtl/sort_count_ram.sv
// Histogram storage: simple dual-port RAM, registered read, no reset.
module sort_count_ram #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // One write and one read per cycle; a same-address read returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/count_sort_core.sv
// Counting-sort engine: histogram a frame, stream it back in ascending order,
// then zero the histogram for the next frame.
module count_sort_core
    import sort_pkg::*;
#(
    parameter int unsigned VALUE_WIDTH = SORT_VALUE_WIDTH,
    parameter int unsigned COUNT_WIDTH = SORT_COUNT_WIDTH
) (
    input  logic             clk_i,
    input  logic             reset_i,
    count_sort_core_if.slave bus,
    output logic             busy_o,
    output logic             overflow_o
);
    localparam logic [VALUE_WIDTH-1:0] ADDR_MAX  = '1;
    localparam logic [VALUE_WIDTH-1:0] ADDR_ONE  = VALUE_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

    sort_state_e            state;
    logic [VALUE_WIDTH-1:0] clear_addr;
    logic [VALUE_WIDTH-1:0] scan_addr;
    logic [COUNT_WIDTH-1:0] total;
    logic [COUNT_WIDTH-1:0] remaining;
    logic [COUNT_WIDTH-1:0] bin_left;
    logic                   rd_pending;
    logic                   scan_done;

    logic                   in_ready_q;
    logic                   out_valid_q;
    logic                   out_last_q;
    logic [VALUE_WIDTH-1:0] out_data_q;

    // Increment pipeline and write-forwarding state.
    logic                   s1_valid;
    logic [VALUE_WIDTH-1:0] s1_addr;
    logic [VALUE_WIDTH-1:0] rd_addr_q;
    logic                   wr_prev_valid;
    logic [VALUE_WIDTH-1:0] wr_prev_addr;
    logic [COUNT_WIDTH-1:0] wr_prev_data;

    logic                   ram_we;
    logic [VALUE_WIDTH-1:0] ram_waddr;
    logic [COUNT_WIDTH-1:0] ram_wdata;
    logic [VALUE_WIDTH-1:0] ram_raddr;
    logic [COUNT_WIDTH-1:0] ram_rdata;

    logic                   in_fire;
    logic                   out_fire;
    logic                   out_free;
    logic [COUNT_WIDTH-1:0] rd_data_fwd;
    logic                   s1_sat;
    logic                   total_sat;
    logic [COUNT_WIDTH-1:0] total_inc;

    logic                   drain_active;
    logic [COUNT_WIDTH-1:0] drain_cnt;
    logic                   drain_have;
    logic                   emit;
    logic                   emit_last;
    logic                   advance;
    logic                   wrap;
    logic                   rd_req;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_q;

    sort_count_ram #(
        .ADDR_WIDTH (VALUE_WIDTH),
        .DATA_WIDTH (COUNT_WIDTH)
    ) u_ram (
        .clk   (clk_i),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Handshakes, forwarding of the write issued alongside the last read, saturating counts.
    always_comb begin
        in_fire     = (state == LOAD) && bus.in_valid && in_ready_q;
        out_fire    = out_valid_q && bus.out_ready;
        out_free    = !out_valid_q || bus.out_ready;
        rd_data_fwd = (wr_prev_valid && (wr_prev_addr == rd_addr_q)) ? wr_prev_data : ram_rdata;
        s1_sat      = (rd_data_fwd == COUNT_MAX);
        total_sat   = (total == COUNT_MAX);
        total_inc   = total_sat ? total : total + COUNT_ONE;
    end

    // Drain scan decisions. After any saturation the total no longer matches the
    // bin sum, so the whole histogram is drained and the frame ends without a last flag.
    always_comb begin
        drain_active = (state == DRAIN) && !scan_done;
        drain_cnt    = rd_pending ? rd_data_fwd : bin_left;
        drain_have   = (drain_cnt != '0);
        emit_last    = !overflow_o && (remaining == COUNT_ONE);
        emit         = drain_active && drain_have && out_free;
        advance      = drain_active &&
                       ((rd_pending && !drain_have) ||
                        (emit && (drain_cnt == COUNT_ONE) && !emit_last));
        wrap         = advance && (scan_addr == ADDR_MAX);
        rd_req       = (drain_active && !rd_pending && (bin_left == '0)) || (advance && !wrap);
    end

    // RAM port steering: CLEAR zero-fill or pipelined increment on write; input or scan on read.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = clear_addr;
        ram_wdata = '0;
        ram_raddr = scan_addr;
        if (state == CLEAR) begin
            ram_we = 1'b1;
        end else if (s1_valid) begin
            ram_we    = 1'b1;
            ram_waddr = s1_addr;
            ram_wdata = s1_sat ? COUNT_MAX : rd_data_fwd + COUNT_ONE;
        end
        if (state == LOAD) begin
            ram_raddr = bus.in_data;
        end else if (advance) begin
            ram_raddr = scan_addr + ADDR_ONE;
        end
    end

    // Increment pipeline stage and record of the previous write for forwarding.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_valid      <= 1'b0;
            s1_addr       <= '0;
            rd_addr_q     <= '0;
            wr_prev_valid <= 1'b0;
            wr_prev_addr  <= '0;
            wr_prev_data  <= '0;
        end else begin
            s1_valid      <= in_fire;
            s1_addr       <= bus.in_data;
            rd_addr_q     <= ram_raddr;
            wr_prev_valid <= ram_we;
            wr_prev_addr  <= ram_waddr;
            wr_prev_data  <= ram_wdata;
        end
    end

    // Main FSM with registered stream and status outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= CLEAR;
            clear_addr  <= '0;
            scan_addr   <= '0;
            total       <= '0;
            remaining   <= '0;
            bin_left    <= '0;
            rd_pending  <= 1'b0;
            scan_done   <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            busy_o      <= 1'b1;
            overflow_o  <= 1'b0;
        end else begin
            if (out_fire) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
            if (s1_valid && s1_sat) begin
                overflow_o <= 1'b1;
            end
            case (state)
                CLEAR: begin
                    clear_addr <= clear_addr + ADDR_ONE;
                    if (clear_addr == ADDR_MAX) begin
                        state      <= LOAD;
                        in_ready_q <= 1'b1;
                        busy_o     <= 1'b0;
                        overflow_o <= 1'b0;
                        total      <= '0;
                    end
                end
                LOAD: begin
                    if (in_fire) begin
                        total <= total_inc;
                        if (total_sat) begin
                            overflow_o <= 1'b1;
                        end
                        if (bus.in_last) begin
                            state      <= DRAIN;
                            in_ready_q <= 1'b0;
                            busy_o     <= 1'b1;
                            remaining  <= total_inc;
                            scan_addr  <= '0;
                            bin_left   <= '0;
                            rd_pending <= 1'b0;
                            scan_done  <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (scan_done) begin
                        if (out_free) begin
                            state     <= CLEAR;
                            scan_done <= 1'b0;
                        end
                    end else begin
                        if (emit) begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= scan_addr;
                            out_last_q  <= emit_last;
                            bin_left    <= drain_cnt - COUNT_ONE;
                            if (remaining != '0) begin
                                remaining <= remaining - COUNT_ONE;
                            end
                            if (emit_last) begin
                                scan_done <= 1'b1;
                            end
                        end else if (rd_pending && drain_have) begin
                            bin_left <= rd_data_fwd;
                        end
                        rd_pending <= rd_req;
                        if (advance) begin
                            if (wrap) begin
                                scan_done <= 1'b1;
                            end else begin
                                scan_addr <= scan_addr + ADDR_ONE;
                            end
                        end
                    end
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_sort_core.sv
// Directed self-checking bench for count_sort_core (default build and a 4-bit-count build).
module tb_count_sort_core;
    import sort_pkg::*;

    localparam int unsigned VW = SORT_VALUE_WIDTH;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    logic busy_a;
    logic ovf_a;
    logic busy_b;
    logic ovf_b;

    count_sort_core_if #(.VALUE_WIDTH(VW)) bus_a ();
    count_sort_core_if #(.VALUE_WIDTH(VW)) bus_b ();

    count_sort_core dut_a (
        .clk_i      (clk),
        .reset_i    (rst_a),
        .bus        (bus_a),
        .busy_o     (busy_a),
        .overflow_o (ovf_a)
    );

    count_sort_core #(.VALUE_WIDTH(VW), .COUNT_WIDTH(4)) dut_b (
        .clk_i      (clk),
        .reset_i    (rst_b),
        .bus        (bus_b),
        .busy_o     (busy_b),
        .overflow_o (ovf_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int got_d[$];
    bit got_l[$];
    int got_lat;

    task automatic send_a(input int vals[$]);
        int c;
        for (int i = 0; i < vals.size(); i++) begin
            @(negedge clk);
            bus_a.in_data  = VW'(vals[i]);
            bus_a.in_last  = (i == vals.size() - 1);
            bus_a.in_valid = 1'b1;
            c = 0;
            while (!bus_a.in_ready && c < 2000) begin
                @(negedge clk);
                c++;
            end
            if (!bus_a.in_ready) begin
                checks++;
                errors++;
                $display("FAIL send_a_timeout: in_ready=%b, required 1", bus_a.in_ready);
            end
            @(posedge clk);
        end
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        bus_a.in_last  = 1'b0;
        checks++;
        if (bus_a.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_last: in_ready=%b, required 0", bus_a.in_ready);
        end
    endtask

    task automatic collect_a(input int n, input bit rnd);
        int cyc;
        bit pv;
        bit pr;
        logic [VW-1:0] pd;
        logic pl;
        got_d.delete();
        got_l.delete();
        got_lat = -1;
        cyc = 1;
        pv = 1'b0;
        pr = 1'b0;
        pd = '0;
        pl = 1'b0;
        while (got_d.size() < n && cyc < 3000) begin
            bus_a.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus_a.out_valid && got_lat < 0) got_lat = cyc - 1;
            if (pv && !pr) begin
                checks++;
                if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== pd || bus_a.out_last !== pl) begin
                    errors++;
                    $display("FAIL hold_stable: valid=%b data=%0d last=%b, required valid=1 data=%0d last=%b",
                             bus_a.out_valid, bus_a.out_data, bus_a.out_last, pd, pl);
                end
            end
            pv = bus_a.out_valid;
            pr = bus_a.out_ready;
            pd = bus_a.out_data;
            pl = bus_a.out_last;
            if (bus_a.out_valid && bus_a.out_ready) begin
                got_d.push_back(int'(bus_a.out_data));
                got_l.push_back(bus_a.out_last);
            end
            @(negedge clk);
            cyc++;
        end
        bus_a.out_ready = 1'b0;
        checks++;
        if (got_d.size() != n) begin
            errors++;
            $display("FAIL out_count: got %0d values, required %0d", got_d.size(), n);
        end
        checks++;
        if (bus_a.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_after_last: out_valid=%b, required 0", bus_a.out_valid);
        end
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_drain: busy=%b, required 1", busy_a);
        end
    endtask

    task automatic wait_ready_a();
        int c;
        c = 0;
        while (!bus_a.in_ready && c < 2000) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (bus_a.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_clear: in_ready=%b, required 1", bus_a.in_ready);
        end
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL busy_in_load: busy=%b, required 0", busy_a);
        end
    endtask

    task automatic test_reset();
        int cyc;
        int busy_bad;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus_a.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: %b, required 0", bus_a.in_ready); end
        checks++;
        if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: %b, required 0", bus_a.out_valid); end
        checks++;
        if (bus_a.out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: %b, required 0", bus_a.out_last); end
        checks++;
        if (bus_a.out_data !== '0) begin errors++; $display("FAIL rst_out_data: %0d, required 0", bus_a.out_data); end
        checks++;
        if (busy_a !== 1'b1) begin errors++; $display("FAIL rst_busy: %b, required 1", busy_a); end
        checks++;
        if (ovf_a !== 1'b0) begin errors++; $display("FAIL rst_overflow: %b, required 0", ovf_a); end
        rst_a = 1'b0;
        rst_b = 1'b0;
        cyc = 0;
        busy_bad = 0;
        while (cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (bus_a.in_ready) break;
            if (busy_a !== 1'b1) busy_bad++;
        end
        checks++;
        if (cyc != 1024) begin
            errors++;
            $display("FAIL clear_length: in_ready rose after %0d cycles, required 1024", cyc);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL busy_during_clear: %0d low cycles, required 0", busy_bad);
        end
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_clear: %b, required 0", busy_a);
        end
    endtask

    task automatic test_basic();
        int exp_d[4] = '{0, 3, 5, 5};
        bit exp_l[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        send_a('{5, 3, 5, 0});
        collect_a(4, 1'b0);
        checks++;
        if (got_lat < 2 || got_lat > 1026) begin
            errors++;
            $display("FAIL basic_latency: %0d cycles, required 2..1026", got_lat);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < got_d.size()) begin
                checks++;
                if (got_d[i] != exp_d[i] || got_l[i] != exp_l[i]) begin
                    errors++;
                    $display("FAIL basic_out[%0d]: data=%0d last=%b, required data=%0d last=%b",
                             i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
                end
            end
        end
        wait_ready_a();
    endtask

    task automatic test_forwarding();
        int exp_d[5] = '{7, 7, 7, 7, 1023};
        bit exp_l[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        send_a('{7, 7, 7, 7, 1023});
        collect_a(5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i < got_d.size()) begin
                checks++;
                if (got_d[i] != exp_d[i] || got_l[i] != exp_l[i]) begin
                    errors++;
                    $display("FAIL fwd_out[%0d]: data=%0d last=%b, required data=%0d last=%b",
                             i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
                end
            end
        end
        checks++;
        if (ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL fwd_overflow: %b, required 0", ovf_a);
        end
        wait_ready_a();
    endtask

    task automatic test_backpressure();
        int exp_d[3] = '{2, 2, 9};
        bit exp_l[3] = '{1'b0, 1'b0, 1'b1};
        send_a('{2, 9, 2});
        collect_a(3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            if (i < got_d.size()) begin
                checks++;
                if (got_d[i] != exp_d[i] || got_l[i] != exp_l[i]) begin
                    errors++;
                    $display("FAIL bp_out[%0d]: data=%0d last=%b, required data=%0d last=%b",
                             i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
                end
            end
        end
        wait_ready_a();
    endtask

    task automatic test_overflow();
        int c;
        int n_out;
        int n_bad;
        int n_last;
        logic ovf_seen;
        c = 0;
        while (!bus_b.in_ready && c < 3000) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (bus_b.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ovf_initial_ready: in_ready=%b, required 1", bus_b.in_ready);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus_b.in_data  = VW'(2);
            bus_b.in_last  = (i == 15);
            bus_b.in_valid = 1'b1;
            c = 0;
            while (!bus_b.in_ready && c < 100) begin
                @(negedge clk);
                c++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        bus_b.in_valid = 1'b0;
        bus_b.in_last  = 1'b0;
        checks++;
        if (ovf_b !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: overflow=%b, required 1", ovf_b);
        end
        n_out = 0;
        n_bad = 0;
        n_last = 0;
        ovf_seen = 1'b0;
        bus_b.out_ready = 1'b1;
        c = 0;
        while (!bus_b.in_ready && c < 4000) begin
            if (bus_b.out_valid) begin
                n_out++;
                if (bus_b.out_data !== VW'(2)) n_bad++;
                if (bus_b.out_last) n_last++;
                if (n_out == 1) ovf_seen = ovf_b;
            end
            @(negedge clk);
            c++;
        end
        bus_b.out_ready = 1'b0;
        checks++;
        if (n_out != 15) begin errors++; $display("FAIL ovf_count: %0d emissions, required 15", n_out); end
        checks++;
        if (n_bad != 0) begin errors++; $display("FAIL ovf_data: %0d values not 2, required 0", n_bad); end
        checks++;
        if (n_last != 0) begin errors++; $display("FAIL ovf_last: %0d last flags, required 0", n_last); end
        checks++;
        if (ovf_seen !== 1'b1) begin errors++; $display("FAIL ovf_in_drain: overflow=%b, required 1", ovf_seen); end
        checks++;
        if (bus_b.in_ready !== 1'b1) begin errors++; $display("FAIL ovf_reload: in_ready=%b, required 1", bus_b.in_ready); end
        checks++;
        if (ovf_b !== 1'b0) begin errors++; $display("FAIL ovf_cleared: overflow=%b, required 0", ovf_b); end
    endtask

    task automatic test_reset_mid_drain();
        int c;
        bus_a.out_ready = 1'b0;
        send_a('{100, 200, 300});
        c = 0;
        while (!bus_a.out_valid && c < 2000) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== VW'(100)) begin
            errors++;
            $display("FAIL mid_first: valid=%b data=%0d, required valid=1 data=100", bus_a.out_valid, bus_a.out_data);
        end
        rst_a = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: %b, required 0", bus_a.out_valid); end
        checks++;
        if (bus_a.out_data !== '0) begin errors++; $display("FAIL mid_rst_data: %0d, required 0", bus_a.out_data); end
        checks++;
        if (bus_a.out_last !== 1'b0) begin errors++; $display("FAIL mid_rst_last: %b, required 0", bus_a.out_last); end
        checks++;
        if (bus_a.in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: %b, required 0", bus_a.in_ready); end
        checks++;
        if (busy_a !== 1'b1) begin errors++; $display("FAIL mid_rst_busy: %b, required 1", busy_a); end
        checks++;
        if (ovf_a !== 1'b0) begin errors++; $display("FAIL mid_rst_overflow: %b, required 0", ovf_a); end
        rst_a = 1'b0;
        wait_ready_a();
        send_a('{4});
        collect_a(1, 1'b0);
        if (got_d.size() > 0) begin
            checks++;
            if (got_d[0] != 4 || got_l[0] != 1'b1) begin
                errors++;
                $display("FAIL mid_new_frame: data=%0d last=%b, required data=4 last=1", got_d[0], got_l[0]);
            end
        end
        wait_ready_a();
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.in_data   = '0;
        bus_a.in_last   = 1'b0;
        bus_a.in_valid  = 1'b0;
        bus_a.out_ready = 1'b0;
        bus_b.in_data   = '0;
        bus_b.in_last   = 1'b0;
        bus_b.in_valid  = 1'b0;
        bus_b.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_forwarding();
        test_backpressure();
        test_overflow();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_sort_core.md
# count_sort_core

Counting-sort engine fed by `uart_sort_bridge`. It accepts a frame of unsigned values over a valid/ready stream and builds a histogram in block RAM. After the frame's last value it drains the values in ascending order, repeats included, on a second valid/ready stream. It then zero-fills the histogram so it is ready for the next frame.

## Interface
- `VALUE_WIDTH`, 10: value width; histogram depth is 2^VALUE_WIDTH bins.
- `COUNT_WIDTH`, 16: width of each bin counter and of the frame-total counter.

- `clk_i`  in  1: single clock.
- `reset_i`  in  1: synchronous, active-high reset.
- `in_data_i`  in  VALUE_WIDTH: input value.
- `in_last_i`  in  1: marks the final value of the frame.
- `in_valid_i`  in  1: input valid.
- `in_ready_o`  out  1: input ready.
- `out_data_o`  out  VALUE_WIDTH: sorted value.
- `out_last_o`  out  1: marks the final sorted value.
- `out_valid_o`  out  1: output valid.
- `out_ready_i`  in  1: output ready.
- `busy_o`  out  1: high in CLEAR and DRAIN.
- `overflow_o`  out  1: sticky; set when any bin or the total saturates; cleared on entry to LOAD.

## Operation
- Transfers: a transfer occurs on a cycle where valid and ready are both high.
- States: CLEAR → LOAD → DRAIN → CLEAR.
- CLEAR:
  - Writes 0 to bins 0..2^VALUE_WIDTH−1, one per cycle, with a sequential address counter.
  - After the final address, go to LOAD.
- LOAD:
  - `in_ready_o`=1.
  - Each transfer performs a read-modify-write `bin[v] += 1`, at one value per cycle.
  - A bin already at 2^COUNT_WIDTH−1 stays there and sets `overflow_o`.
  - The frame total increments with the same saturation rule, which also sets `overflow_o`.
  - A transfer carrying `in_last_i`=1 is counted, then the state goes to DRAIN.
- DRAIN:
  - Scans bins in ascending order, skipping zero bins at one bin per cycle.
  - A bin holding count c emits its index c times.
  - A remaining counter is loaded with the frame total.
  - `out_last_o` is asserted when remaining = 1.
  - After that transfer, go to CLEAR.
  - If the scan wraps past the top bin with remaining > 0 (only possible after overflow), go to CLEAR without asserting `out_last_o`.
- Reset at any time: all outputs go to their reset values and the state goes to CLEAR. A partial frame is discarded.

## Timing
- Reset values: `in_ready_o`=0, `out_valid_o`=0, `out_last_o`=0, `out_data_o`=0, `busy_o`=1, `overflow_o`=0.
- CLEAR duration:
  - Exactly 2^VALUE_WIDTH cycles after reset is released.
  - `in_ready_o` rises on the following cycle.
  - Bins are not readable or incrementable during CLEAR.
- RAM: synchronous read with 1-cycle latency and one write port.
- Back-to-back updates to the same bin (or to a bin currently being written):
  - Forward the pending write value; never use the stale RAM data.
  - Throughput stays at one value per cycle with no bubbles.
- `in_ready_o` falls on the cycle after the last transfer. No value is accepted in DRAIN or CLEAR.
- First output:
  - `out_valid_o` rises no earlier than 2 cycles after the last input transfer.
  - It rises no later than 2^VALUE_WIDTH+2 cycles after it.
- Output stability: `out_data_o` and `out_last_o` are registered and must stay stable while `out_valid_o`=1 and `out_ready_i`=0.
- Output rate: with `out_ready_i` held high, repeats of one bin stream at one per cycle. Moving to the next non-empty bin adds at most the skip cycles plus one read latency.
- End of frame: `out_valid_o` falls the cycle after the `out_last_o` transfer. `busy_o` stays high through the following CLEAR.

## Structure
- Package `sort_pkg` holds:
  - the state enum `sort_state_e` (CLEAR, LOAD, DRAIN);
  - default width constants `SORT_VALUE_WIDTH`=10 and `SORT_COUNT_WIDTH`=16.
- Sub-module `sort_count_ram`:
  - simple dual-port RAM, 2^VALUE_WIDTH × COUNT_WIDTH;
  - synchronous read, 1-cycle latency;
  - no reset, inferable as block RAM.
- Top of block: FSM, increment pipeline with forwarding, scan and remaining counters, output register.

## Test plan
- Reset released → `in_ready_o`=0 and `busy_o`=1 for 1024 cycles, then `in_ready_o`=1 and `busy_o`=0.
- Input 5, 3, 5, 0 (last on 0) → output 0, 3, 5, 5 with `out_last_o` on the second 5; CLEAR follows, then ready for the next frame.
- Input 7, 7, 7, 7 back-to-back, then 1023 (last) → 7 ×4 then 1023. This checks forwarding. `overflow_o`=0.
- Input 2, 9, 2 (last) with `out_ready_i` toggling randomly → exactly 2, 2, 9 in order, with data held stable under backpressure.
- Build with COUNT_WIDTH=4; input 16 copies of value 2 (last on the 16th) → `overflow_o`=1. Per the DRAIN rule: 15 emissions of 2, no `out_last_o`, then CLEAR, and `overflow_o` clears when LOAD is re-entered.
- Reset asserted mid-DRAIN → outputs at reset values the next cycle. After CLEAR, a frame of 4 (last) yields only 4 with `out_last_o`, and no stale bins.
